// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/flag inputs and control word outputs of control_sequencer
interface control_sequencer_if;
  logic [15:0] ir_in;
  logic        z_flag;
  logic [40:0] control_word;
  logic [2:0]  t_state;
  logic        halted;

  modport master (
    input  ir_in,
    input  z_flag,
    output control_word,
    output t_state,
    output halted
  );

  modport slave (
    output ir_in,
    output z_flag,
    input  control_word,
    input  t_state,
    input  halted
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute control unit driving the ALU_System control word
module control_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  control_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC1   = 3'd3,
    S_EXEC2   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  // Field layout of the 41-bit control word, MSB first.
  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_INC   = 2'b11;

  state_t state;
  state_t next_state;
  logic   halted_q;
  ctrl_t  cw;

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] rd_onehot;

  assign opcode    = bus.ir_in[15:12];
  assign rd        = bus.ir_in[11:10];
  assign rs        = bus.ir_in[9:8];
  // R1 is the MSB of the enable nibble, so Rd=0 selects 4'b1000.
  assign rd_onehot = 4'b1000 >> rd;

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      4'h3:    alu_code = 4'b0100;
      4'h4:    alu_code = 4'b0110;
      4'h5:    alu_code = 4'b0111;
      4'h6:    alu_code = 4'b1000;
      default: alu_code = 4'b0000;
    endcase
  endfunction

  // State register and registered halt indication; reset abandons any instruction in flight.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= S_INIT;
      halted_q <= 1'b0;
    end else begin
      state    <= next_state;
      halted_q <= (next_state == S_HALT);
    end
  end

  // Next-state selection and control word decode from state, IR and Z flag.
  always_comb begin
    cw         = '0;
    cw.mem_cs  = 1'b1;
    next_state = state;
    case (state)
      S_INIT: begin
        cw.rf_fun_sel  = FUN_CLEAR;
        cw.rf_rsel     = 4'b1111;
        cw.rf_tsel     = 4'b1111;
        cw.arf_fun_sel = FUN_CLEAR;
        // Only a zero reset vector is supported: clearing PC with the rest of the ARF gives it.
        cw.arf_reg_sel = (PC_RESET == 8'h00) ? 4'b1111 : 4'b0111;
        next_state     = S_FETCH_L;
      end
      S_FETCH_L, S_FETCH_H: begin
        cw.arf_outd_sel = 2'b00;
        cw.mem_cs       = 1'b0;
        cw.mem_wr       = 1'b0;
        cw.ir_enable    = 1'b1;
        cw.ir_fun_sel   = FUN_LOAD;
        cw.ir_lh        = (state == S_FETCH_H);
        cw.arf_reg_sel  = 4'b1000;
        cw.arf_fun_sel  = FUN_INC;
        next_state      = (state == S_FETCH_L) ? S_FETCH_H : S_EXEC1;
      end
      S_EXEC1: begin
        next_state = S_FETCH_L;
        if (opcode == HALT_OP) begin
          next_state = S_HALT;
        end else begin
          case (opcode)
            4'h0: begin
              cw.mux_a_sel  = 2'b10;
              cw.rf_fun_sel = FUN_LOAD;
              cw.rf_rsel    = rd_onehot;
            end
            4'h1, 4'h2: begin
              cw.mux_b_sel   = 2'b10;
              cw.arf_fun_sel = FUN_LOAD;
              cw.arf_reg_sel = 4'b0100;
              next_state     = S_EXEC2;
            end
            4'h3, 4'h4, 4'h5, 4'h6: begin
              cw.rf_outa_sel = {1'b1, rd};
              cw.rf_outb_sel = {1'b1, rs};
              cw.mux_c_sel   = 1'b0;
              cw.alu_fun_sel = alu_code(opcode);
              cw.mux_a_sel   = 2'b00;
              cw.rf_fun_sel  = FUN_LOAD;
              cw.rf_rsel     = rd_onehot;
            end
            4'h7: begin
              cw.mux_b_sel   = 2'b10;
              cw.arf_fun_sel = FUN_LOAD;
              cw.arf_reg_sel = 4'b1000;
            end
            4'h8: begin
              if (bus.z_flag) begin
                cw.mux_b_sel   = 2'b10;
                cw.arf_fun_sel = FUN_LOAD;
                cw.arf_reg_sel = 4'b1000;
              end
            end
            default: begin
            end
          endcase
        end
      end
      S_EXEC2: begin
        next_state = S_FETCH_L;
        if (opcode == 4'h1) begin
          cw.arf_outd_sel = 2'b01;
          cw.mem_cs       = 1'b0;
          cw.mem_wr       = 1'b0;
          cw.mux_a_sel    = 2'b01;
          cw.rf_fun_sel   = FUN_LOAD;
          cw.rf_rsel      = rd_onehot;
        end else if (opcode == 4'h2) begin
          cw.rf_outa_sel  = {1'b1, rs};
          cw.mux_c_sel    = 1'b0;
          cw.alu_fun_sel  = 4'b0000;
          cw.arf_outd_sel = 2'b01;
          cw.mem_cs       = 1'b0;
          cw.mem_wr       = 1'b1;
        end
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_INIT;
      end
    endcase
  end

  assign bus.control_word = cw;
  assign bus.t_state      = state;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  logic Clock;
  logic Reset;
  control_sequencer_if bus();

  control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Field positions in the word, MSB first, and their widths.
  localparam int F_OUTA = 0, F_OUTB = 1, F_RFFUN = 2, F_RSEL = 3, F_TSEL = 4, F_ALU = 5;
  localparam int F_OUTC = 6, F_OUTD = 7, F_ARFFUN = 8, F_REGSEL = 9, F_IRLH = 10, F_IREN = 11;
  localparam int F_IRFUN = 12, F_WR = 13, F_CS = 14, F_MUXA = 15, F_MUXB = 16, F_MUXC = 17;
  int fw[18] = '{3, 3, 2, 4, 4, 4, 2, 2, 2, 4, 1, 1, 2, 1, 1, 2, 2, 1};

  function automatic logic [40:0] expected_word(input int st, input logic [15:0] ir, input logic z);
    int f[18];
    int op, rdv, rsv;
    logic [40:0] w;
    for (int i = 0; i < 18; i++) f[i] = 0;
    f[F_CS] = 1;
    op  = int'(ir[15:12]);
    rdv = int'(ir[11:10]);
    rsv = int'(ir[9:8]);
    if (st == 0) begin
      f[F_RSEL] = 15; f[F_TSEL] = 15; f[F_REGSEL] = 15;
    end else if (st == 1 || st == 2) begin
      f[F_CS] = 0; f[F_IREN] = 1; f[F_IRFUN] = 1;
      f[F_REGSEL] = 8; f[F_ARFFUN] = 3; f[F_IRLH] = (st == 2) ? 1 : 0;
    end else if (st == 3) begin
      if (op == 0) begin
        f[F_MUXA] = 2; f[F_RFFUN] = 1; f[F_RSEL] = 1 << (3 - rdv);
      end else if (op == 1 || op == 2) begin
        f[F_MUXB] = 2; f[F_ARFFUN] = 1; f[F_REGSEL] = 4;
      end else if (op >= 3 && op <= 6) begin
        f[F_OUTA] = 4 + rdv; f[F_OUTB] = 4 + rsv;
        f[F_ALU] = (op == 3) ? 4 : (op == 4) ? 6 : (op == 5) ? 7 : 8;
        f[F_RFFUN] = 1; f[F_RSEL] = 1 << (3 - rdv);
      end else if (op == 7 || (op == 8 && z)) begin
        f[F_MUXB] = 2; f[F_ARFFUN] = 1; f[F_REGSEL] = 8;
      end
    end else if (st == 4) begin
      if (op == 1) begin
        f[F_OUTD] = 1; f[F_CS] = 0; f[F_MUXA] = 1; f[F_RFFUN] = 1; f[F_RSEL] = 1 << (3 - rdv);
      end else if (op == 2) begin
        f[F_OUTA] = 4 + rsv; f[F_OUTD] = 1; f[F_CS] = 0; f[F_WR] = 1;
      end
    end
    w = '0;
    for (int i = 0; i < 18; i++) w = (w << fw[i]) | 41'(f[i]);
    return w;
  endfunction

  // Reference sequencing: 0 -> 1 -> 2 -> 3 -> (4 for LD/ST | 5 for HALT | 1) ; 4 -> 1 ; 5 holds.
  int m_state  = 0;
  bit m_halted = 0;
  bit m_valid  = 0;

  always @(posedge Clock) begin
    if (!Reset) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: m_state = 3;
        3: begin
          if (bus.ir_in[15:12] == 4'hF) m_state = 5;
          else if (bus.ir_in[15:12] == 4'h1 || bus.ir_in[15:12] == 4'h2) m_state = 4;
          else m_state = 1;
        end
        4: m_state = 1;
        default: m_state = 5;
      endcase
    end
    m_halted = (m_state == 5);
    m_valid  = 1;
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      chk("t_state", 41'(bus.t_state), 41'(m_state));
      chk("halted", 41'(bus.halted), 41'(m_halted));
      chk("control_word", bus.control_word, expected_word(m_state, bus.ir_in, bus.z_flag));
    end
  end

  localparam logic [40:0] W_IDLE    = 41'h000_0000_0020;
  localparam logic [40:0] W_INIT    = 41'h001_FE00_7820;
  localparam logic [40:0] W_FETCH_L = 41'h000_0001_C280;
  localparam logic [40:0] W_FETCH_H = 41'h000_0001_C680;

  logic [15:0] prog   [12] = '{16'h0C5A, 16'h1420, 16'h2300, 16'h3600, 16'h4900, 16'h5E00,
                               16'h6100, 16'h7080, 16'h8040, 16'h8040, 16'h9000, 16'hF000};
  logic        zs     [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        e1_has [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [40:0] e1_exp [12] = '{41'h002_2000_0030, 41'h000_0000_A024, 41'h0, 41'h172_8080_0020,
                               41'h0, 41'h0, 41'h0, 41'h0, W_IDLE, 41'h000_0000_C024, W_IDLE, W_IDLE};
  logic        e2_has [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [40:0] e2_exp [12] = '{41'h0, 41'h002_8002_0008, 41'h1C0_0002_0040, 41'h0, 41'h0, 41'h0,
                               41'h0, 41'h0, 41'h0, 41'h0, 41'h0, 41'h0};

  task automatic tick;
    @(posedge Clock);
    #2;
  endtask

  initial begin
    logic [3:0] op;
    Reset      = 1'b0;
    bus.ir_in  = 16'h0000;
    bus.z_flag = 1'b0;
    tick;
    tick;
    #1;
    chk("reset_t_state", 41'(bus.t_state), 41'd0);
    chk("reset_halted", 41'(bus.halted), 41'd0);
    chk("init_word", bus.control_word, W_INIT);
    Reset = 1'b1;
    tick;
    #1;
    chk("fetch_l_t_state", 41'(bus.t_state), 41'd1);
    chk("fetch_l_word", bus.control_word, W_FETCH_L);

    for (int i = 0; i < 12; i++) begin
      bus.ir_in  = prog[i];
      bus.z_flag = zs[i];
      op = prog[i][15:12];
      tick;
      #1;
      chk("fetch_h_word", bus.control_word, W_FETCH_H);
      tick;
      #1;
      chk("exec1_t_state", 41'(bus.t_state), 41'd3);
      if (e1_has[i]) chk($sformatf("exec1_word_%h_z%0d", prog[i], zs[i]), bus.control_word, e1_exp[i]);
      if (op == 4'h1 || op == 4'h2) begin
        tick;
        #1;
        chk("exec2_t_state", 41'(bus.t_state), 41'd4);
        if (e2_has[i]) chk($sformatf("exec2_word_%h", prog[i]), bus.control_word, e2_exp[i]);
      end
      if (op != 4'hF) begin
        tick;
        #1;
        chk("back_to_fetch", 41'(bus.t_state), 41'd1);
      end
    end

    for (int k = 0; k < 10; k++) begin
      tick;
      #1;
      chk("halt_state", 41'(bus.t_state), 41'd5);
      chk("halt_flag", 41'(bus.halted), 41'd1);
      chk("halt_word", bus.control_word, W_IDLE);
    end

    Reset = 1'b0;
    tick;
    #1;
    chk("halt_reset_state", 41'(bus.t_state), 41'd0);
    chk("halt_reset_flag", 41'(bus.halted), 41'd0);
    Reset = 1'b1;
    tick;

    bus.ir_in  = 16'h1420;
    bus.z_flag = 1'b0;
    tick;
    tick;
    tick;
    #1;
    chk("ld_exec2_state", 41'(bus.t_state), 41'd4);
    Reset = 1'b0;
    tick;
    #1;
    chk("abort_state", 41'(bus.t_state), 41'd0);
    chk("abort_word", bus.control_word, W_INIT);
    chk("abort_no_rf_load", 41'(bus.control_word[34:33]), 41'd0);
    Reset = 1'b1;
    tick;
    #1;
    chk("abort_restart", 41'(bus.t_state), 41'd1);
    tick;
    tick;
    @(posedge Clock);
    #6;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
